mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the pipeline's instruction-fetch (IF) port and data-memory (DM) port.

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester (IF, DM) and shared-memory signals of mem_port_arbiter.
// slave: arbiter side; master: core/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;
  logic              stall_if;
  logic              stall_dm;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              mem_timeout;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata, mem_ack,
    output if_rdata, if_ready,
    output dm_rdata, dm_ready,
    output stall_if, stall_dm,
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_timeout
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata, mem_ack,
    input  if_rdata, if_ready,
    input  dm_rdata, dm_ready,
    input  stall_if, stall_dm,
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_timeout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between IF and DM.
// Ports: clk, reset (async, low), bus (slave modport).
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SFULL = SW'(STARVE_MAX);
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_DM
  } state_t;

  state_t            state, stateNx;
  logic              memReq, memReqNx;
  logic              memWe, memWeNx;
  logic              memTo, memToNx;
  logic [ADDR_W-1:0] memAddr, memAddrNx;
  logic [DATA_W-1:0] memWdata, memWdataNx;
  logic [SW-1:0]     starveCnt, starveNx;
  logic [WW-1:0]     waitCnt, waitNx;

  logic idle;
  logic starved;
  logic grantDm;
  logic grantIf;
  logic timedOut;
  logic ifReady;
  logic dmReady;

  assign idle    = (state == IDLE);
  assign starved = bus.if_req & (starveCnt == SFULL);
  assign grantDm = idle & bus.dm_req & ~starved;
  assign grantIf = idle & bus.if_req & ~grantDm;

  // An ack arriving in the last allowed cycle still wins.
  assign timedOut = ~idle & ~bus.mem_ack
                  & (waitCnt == WLAST);

  always_comb begin
    stateNx    = state;
    memReqNx   = memReq;
    memWeNx    = memWe;
    memAddrNx  = memAddr;
    memWdataNx = memWdata;
    memToNx    = memTo;
    starveNx   = starveCnt;
    waitNx     = waitCnt;
    unique case (state)
      IDLE: begin
        starveNx = '0;
        if (grantDm) begin
          stateNx    = BUSY_DM;
          memReqNx   = 1'b1;
          memWeNx    = bus.dm_we;
          memAddrNx  = bus.dm_addr;
          memWdataNx = bus.dm_wdata;
          waitNx     = '0;
          // A full count would have granted IF,
          // so this cannot pass STARVE_MAX.
          if (bus.if_req) begin
            starveNx = starveCnt + 1'b1;
          end
        end else if (grantIf) begin
          stateNx    = BUSY_IF;
          memReqNx   = 1'b1;
          memWeNx    = 1'b0;
          memAddrNx  = bus.if_addr;
          memWdataNx = '0;
          waitNx     = '0;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (bus.mem_ack) begin
          stateNx  = IDLE;
          memReqNx = 1'b0;
        end else if (timedOut) begin
          stateNx  = IDLE;
          memReqNx = 1'b0;
          memToNx  = 1'b1;
        end else begin
          waitNx = waitCnt + 1'b1;
        end
      end
      default: stateNx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      memReq    <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= '0;
      memWdata  <= '0;
      memTo     <= 1'b0;
      starveCnt <= '0;
      waitCnt   <= '0;
    end else begin
      state     <= stateNx;
      memReq    <= memReqNx;
      memWe     <= memWeNx;
      memAddr   <= memAddrNx;
      memWdata  <= memWdataNx;
      memTo     <= memToNx;
      starveCnt <= starveNx;
      waitCnt   <= waitNx;
    end
  end

  // A requester that dropped req mid-access gets
  // no ready pulse for it.
  assign ifReady = (state == BUSY_IF)
                 & bus.mem_ack & bus.if_req;
  assign dmReady = (state == BUSY_DM)
                 & bus.mem_ack & bus.dm_req;

  assign bus.if_ready = ifReady;
  assign bus.dm_ready = dmReady;
  assign bus.if_rdata = ifReady ? bus.mem_rdata : '0;
  assign bus.dm_rdata = (dmReady & ~memWe)
                      ? bus.mem_rdata : '0;

  assign bus.stall_if = bus.if_req & ~ifReady;
  assign bus.stall_dm = bus.dm_req & ~dmReady;

  assign bus.mem_req     = memReq;
  assign bus.mem_we      = memWe;
  assign bus.mem_addr    = memAddr;
  assign bus.mem_wdata   = memWdata;
  assign bus.mem_timeout = memTo;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios,
// then random traffic against a transaction model.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;
  localparam int TMO  = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW),
    .STARVE_MAX(SMAX), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int nCmp = 0;
  int nBad = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [31:0] memWord(
    input logic [31:0] a);
    if (a == 32'h0) return 32'h2002_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
  endfunction

  // memory responder controls (written by main only)
  int memMode  = 0;
  int memDelay = 0;
  bit strayEn  = 0;
  int strayReq = 0;

  int memCnt    = 0;
  int curDelay  = 0;
  int strayDone = 0;

  function automatic int pickDelay();
    if (memMode == 0) return memDelay;
    if (memMode == 2) return 100000;
    if ($urandom_range(199) == 0) return 100000;
    return int'($urandom_range(3));
  endfunction

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = $urandom;
      if (!reset) begin
        memCnt = 0;
      end else if (bus.mem_req) begin
        if (memCnt == 0) curDelay = pickDelay();
        if (memCnt == curDelay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = memWord(bus.mem_addr);
          memCnt = 0;
        end else begin
          memCnt++;
        end
      end else begin
        memCnt = 0;
        if (strayReq != strayDone ||
            (strayEn && $urandom_range(15) == 0))
          bus.mem_ack = 1'b1;
        strayDone = strayReq;
      end
    end
  end

  // transaction model: the access in flight, if any
  bit          mBusy;
  bit          mDm;
  bit          mWe;
  bit          mTo;
  logic [31:0] mAddr;
  logic [31:0] mWdata;
  int          mAge;
  int          mStreak;
  bit          prevReq;
  logic [32:0] grantLog[$];

  task automatic modelReset();
    mBusy = 0; mDm = 0; mWe = 0; mTo = 0;
    mAddr = '0; mWdata = '0;
    mAge = 0; mStreak = 0; prevReq = 0;
  endtask

  task automatic modelStep();
    bit dmWins;
    if (mBusy) begin
      if (bus.mem_ack) begin
        mBusy = 0;
      end else if (mAge + 1 == TMO) begin
        mBusy = 0;
        mTo   = 1;
      end else begin
        mAge++;
      end
    end else begin
      dmWins = bus.dm_req &&
               !(bus.if_req && mStreak == SMAX);
      if (dmWins) begin
        mBusy = 1; mDm = 1; mAge = 0;
        mWe = bus.dm_we;
        mAddr = bus.dm_addr;
        mWdata = bus.dm_wdata;
        if (!bus.if_req) mStreak = 0;
        else if (mStreak < SMAX) mStreak++;
      end else if (bus.if_req) begin
        mBusy = 1; mDm = 0; mAge = 0;
        mWe = 0;
        mAddr = bus.if_addr;
        mWdata = '0;
        mStreak = 0;
      end else begin
        mStreak = 0;
      end
    end
  endtask

  initial begin
    bit eIf, eDm;
    logic [31:0] eIfD, eDmD;
    modelReset();
    forever begin
      @(negedge clk);
      if (!reset) begin
        modelReset();
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_timeout", bus.mem_timeout, 0);
        chk("rst_if_ready", bus.if_ready, 0);
        chk("rst_dm_ready", bus.dm_ready, 0);
      end else begin
        eIf = mBusy && !mDm && bus.mem_ack
           && bus.if_req;
        eDm = mBusy && mDm && bus.mem_ack
           && bus.dm_req;
        eIfD = eIf ? memWord(mAddr) : '0;
        eDmD = (eDm && !mWe) ? memWord(mAddr) : '0;
        chk("if_ready", bus.if_ready, eIf);
        chk("dm_ready", bus.dm_ready, eDm);
        chk("if_rdata", bus.if_rdata, eIfD);
        chk("dm_rdata", bus.dm_rdata, eDmD);
        chk("stall_if", bus.stall_if,
            bus.if_req && !eIf);
        chk("stall_dm", bus.stall_dm,
            bus.dm_req && !eDm);
        chk("mem_req", bus.mem_req, mBusy);
        chk("mem_we", bus.mem_we, mWe);
        chk("mem_addr", bus.mem_addr, mAddr);
        chk("mem_wdata", bus.mem_wdata, mWdata);
        chk("mem_timeout", bus.mem_timeout, mTo);
        if (bus.mem_req && !prevReq)
          grantLog.push_back({bus.mem_we,
                              bus.mem_addr});
        prevReq = bus.mem_req;
        modelStep();
      end
    end
  end

  bit          sIfRdy, sDmRdy, sStallIf;
  bit          sMemReq, sTo;
  logic [31:0] sIfData;

  task automatic sampleNeg();
    @(negedge clk);
    #1;
    sIfRdy   = bus.if_ready;
    sDmRdy   = bus.dm_ready;
    sStallIf = bus.stall_if;
    sMemReq  = bus.mem_req;
    sTo      = bus.mem_timeout;
    sIfData  = bus.if_rdata;
  endtask

  task automatic toDrive();
    @(posedge clk);
    #1;
  endtask

  task automatic chkGrant(input string name,
                          input int idx,
                          input logic [32:0] exp);
    if (grantLog.size() > idx)
      chk(name, grantLog[idx], exp);
    else
      chk(name, grantLog.size(), idx + 1);
  endtask

  initial begin
    int stallN, dmAt, ifAt, k, busyN;
    bit got, seenTo, toReq, ifDone;
    logic [31:0] data;
    bit ifAct, dmAct;
    int ifWait, dmWait;

    bus.if_req = 0; bus.if_addr = '0;
    bus.dm_req = 0; bus.dm_we = 0;
    bus.dm_addr = '0; bus.dm_wdata = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) toDrive();
    reset = 1'b1;
    toDrive();

    // IF alone, ack one cycle after mem_req
    memMode = 0; memDelay = 1;
    grantLog.delete();
    bus.if_addr = 32'h0; bus.if_req = 1;
    stallN = 0; got = 0; data = '0;
    for (int i = 0; i < 10; i++) begin
      sampleNeg();
      if (sStallIf) stallN++;
      if (sIfRdy) begin got = 1; data = sIfData; end
      toDrive();
      if (got) begin bus.if_req = 0; break; end
    end
    chk("t1_ready", got, 1);
    chk("t1_rdata", data, 32'h2002_0005);
    chk("t1_stall_cycles", stallN, 2);
    chk("t1_ngrant", grantLog.size(), 1);
    chkGrant("t1_grant", 0, 33'h0);

    // IF and DM store together: DM, idle, IF
    memDelay = 0;
    toDrive();
    grantLog.delete();
    bus.if_addr = 32'h100; bus.if_req = 1;
    bus.dm_addr = 32'h54; bus.dm_we = 1;
    bus.dm_wdata = 32'h7; bus.dm_req = 1;
    stallN = 0; dmAt = -1; ifAt = -1;
    for (int i = 0; i < 20; i++) begin
      sampleNeg();
      if (sStallIf) stallN++;
      if (sDmRdy) dmAt = i;
      if (sIfRdy) ifAt = i;
      toDrive();
      if (sDmRdy) begin
        bus.dm_req = 0; bus.dm_we = 0;
      end
      if (sIfRdy) begin bus.if_req = 0; break; end
    end
    chk("t2_dm_ready_cycle", dmAt, 1);
    chk("t2_if_ready_cycle", ifAt, 3);
    chk("t2_stall_if_cycles", stallN, 3);
    chkGrant("t2_grant0", 0, 33'h1_0000_0054);
    chkGrant("t2_grant1", 1, 33'h0_0000_0100);

    // DM streams 6 loads while IF waits
    toDrive();
    grantLog.delete();
    k = 0; ifDone = 0;
    bus.dm_we = 0; bus.dm_addr = 32'h200;
    bus.dm_req = 1;
    bus.if_addr = 32'h300; bus.if_req = 1;
    for (int i = 0; i < 60; i++) begin
      sampleNeg();
      toDrive();
      if (sDmRdy) begin
        k++;
        if (k == 6) bus.dm_req = 0;
        else bus.dm_addr = 32'h200 + 32'(4 * k);
      end
      if (sIfRdy) begin
        bus.if_req = 0; ifDone = 1;
      end
      if (k == 6 && ifDone) break;
    end
    chk("t3_ngrant", grantLog.size(), 7);
    chkGrant("t3_g0", 0, 33'h200);
    chkGrant("t3_g1", 1, 33'h204);
    chkGrant("t3_g2", 2, 33'h208);
    chkGrant("t3_g3", 3, 33'h20C);
    chkGrant("t3_g4_if", 4, 33'h300);
    chkGrant("t3_g5", 5, 33'h210);
    chkGrant("t3_g6", 6, 33'h214);

    // withheld ack: timeout, then regrant
    toDrive();
    memMode = 2;
    grantLog.delete();
    bus.dm_we = 0; bus.dm_addr = 32'h400;
    bus.dm_req = 1;
    busyN = 0; seenTo = 0; toReq = 1;
    for (int i = 0; i < 120; i++) begin
      sampleNeg();
      if (sMemReq) busyN++;
      if (sTo) begin
        seenTo = 1; toReq = sMemReq;
        memMode = 0; memDelay = 0;
      end
      toDrive();
      if (seenTo) break;
    end
    chk("t4_timeout_seen", seenTo, 1);
    chk("t4_busy_cycles", busyN, TMO);
    chk("t4_req_dropped", toReq, 0);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      sampleNeg();
      if (sDmRdy) got = 1;
      toDrive();
      if (got) begin bus.dm_req = 0; break; end
    end
    chk("t4_regrant_done", got, 1);
    chk("t4_flag_sticky", sTo, 1);
    chk("t4_ngrant", grantLog.size(), 2);

    // reset during BUSY_DM
    toDrive();
    memMode = 2;
    bus.dm_addr = 32'h500; bus.dm_req = 1;
    bus.if_addr = 32'h600; bus.if_req = 1;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      sampleNeg();
      if (sMemReq) begin got = 1; break; end
      toDrive();
    end
    chk("t5_busy_reached", got, 1);
    #1 reset = 1'b0;
    #1;
    chk("t5_async_mem_req", bus.mem_req, 0);
    chk("t5_no_dm_ready", bus.dm_ready, 0);
    chk("t5_timeout_clr", bus.mem_timeout, 0);
    memMode = 0; memDelay = 0;
    toDrive();
    sampleNeg();
    toDrive();
    #1 reset = 1'b1;
    grantLog.delete();
    dmAt = 0; ifDone = 0;
    for (int i = 0; i < 20; i++) begin
      sampleNeg();
      toDrive();
      if (sDmRdy) begin bus.dm_req = 0; dmAt = 1; end
      if (sIfRdy) begin bus.if_req = 0; ifDone = 1; end
      if (dmAt == 1 && ifDone) break;
    end
    chkGrant("t5_first_dm", 0, 33'h500);
    chkGrant("t5_then_if", 1, 33'h600);

    // stray acks while idle
    sampleNeg();
    strayReq++;
    toDrive();
    sampleNeg();
    chk("t6_no_if_ready", sIfRdy, 0);
    chk("t6_no_dm_ready", sDmRdy, 0);
    chk("t6_no_req", sMemReq, 0);
    strayReq++;
    toDrive();
    bus.if_addr = 32'h700; bus.if_req = 1;
    sampleNeg();
    chk("t6_req_ack_idle", sIfRdy, 0);
    chk("t6_still_stall", sStallIf, 1);
    toDrive();
    sampleNeg();
    chk("t6_granted", sMemReq, 1);
    chk("t6_served", sIfRdy, 1);
    toDrive();
    bus.if_req = 0;

    // random traffic
    memMode = 1; strayEn = 1;
    ifAct = 0; dmAct = 0; ifWait = 0; dmWait = 0;
    for (int c = 0; c < 4000; c++) begin
      sampleNeg();
      toDrive();
      if (ifAct) begin
        ifWait++;
        if (sIfRdy || $urandom_range(299) == 0) begin
          ifAct = 0; bus.if_req = 0;
        end else if (ifWait > 400) begin
          chk("if_wait_bound", ifWait, 400);
          ifAct = 0; bus.if_req = 0;
        end
      end else if ($urandom_range(2) == 0) begin
        ifAct = 1; ifWait = 0;
        bus.if_addr = $urandom;
        bus.if_req = 1;
      end
      if (dmAct) begin
        dmWait++;
        if (sDmRdy || $urandom_range(299) == 0) begin
          dmAct = 0; bus.dm_req = 0;
        end else if (dmWait > 400) begin
          chk("dm_wait_bound", dmWait, 400);
          dmAct = 0; bus.dm_req = 0;
        end
      end else if ($urandom_range(2) == 0) begin
        dmAct = 1; dmWait = 0;
        bus.dm_we = 1'($urandom);
        bus.dm_addr = $urandom;
        bus.dm_wdata = $urandom;
        bus.dm_req = 1;
      end
    end
    bus.if_req = 0; bus.dm_req = 0;
    repeat (3) toDrive();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end
endmodule
